// File: rtl/axi_ux_resp_arb.sv
// axi_ux_resp_arb: registered, arbitrated concentrator for per-tile
// AXI response channels; round-robin or addressed source selection.
module axi_ux_resp_arb #(
  parameter int BW        = 32,
  parameter int TILES     = 16,
  parameter int ADDR_TILE = 4,
  parameter int MODE      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_TILE-1:0]    sel_addr,
  input  logic                    AXI_READY,
  output logic                    AXI_VALID,
  output logic [1:0]              AXI_RESP,
  output logic [BW-1:0]           AXI_DATA,
  output logic [ADDR_TILE-1:0]    AXI_TID,
  input  logic [2*TILES-1:0]      tile_AXI_RESP,
  input  logic [TILES-1:0]        tile_AXI_VALID,
  input  logic [BW*TILES-1:0]     tile_AXI_DATA,
  output logic [TILES-1:0]        tile_AXI_READY
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [ADDR_TILE-1:0]   rr_ptr;
  logic [ADDR_TILE-1:0]   rr_hi;
  logic [ADDR_TILE-1:0]   rr_lo;
  logic                   hi_vld;
  logic                   lo_vld;
  logic                   sel_vld;
  logic                   grant_valid;
  logic [ADDR_TILE-1:0]   g;
  logic [BW-1:0]          g_data;
  logic [1:0]             g_resp;
  logic                   load;
  logic                   fire;
  logic [ADDR_TILE-1:0]   rr_nxt;

  assign AXI_VALID = (state_q == FULL);
  assign load      = ~AXI_VALID | AXI_READY;

  // Round-robin: first valid at/after rr_ptr, else lowest valid (wrap).
  always_comb begin
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    rr_hi   = '0;
    rr_lo   = '0;
    sel_vld = 1'b0;
    for (int i = TILES - 1; i >= 0; i--) begin
      if (tile_AXI_VALID[i]) begin
        lo_vld = 1'b1;
        rr_lo  = ADDR_TILE'(i);
        if (i >= int'(rr_ptr)) begin
          hi_vld = 1'b1;
          rr_hi  = ADDR_TILE'(i);
        end
      end
    end
    for (int i = 0; i < TILES; i++) begin
      if (ADDR_TILE'(i) == sel_addr && tile_AXI_VALID[i])
        sel_vld = 1'b1;
    end
  end

  always_comb begin
    if (MODE == 1) begin
      grant_valid = sel_vld;
      g           = sel_vld ? sel_addr : '0;
    end else begin
      grant_valid = hi_vld | lo_vld;
      g           = hi_vld ? rr_hi : rr_lo;
    end
  end

  always_comb begin
    g_data = '0;
    g_resp = '0;
    for (int i = 0; i < TILES; i++) begin
      if (ADDR_TILE'(i) == g) begin
        g_data = tile_AXI_DATA[BW*i +: BW];
        g_resp = tile_AXI_RESP[2*i +: 2];
      end
    end
  end

  assign fire           = load & grant_valid & ~rst;
  assign tile_AXI_READY = fire ? (TILES'(1) << g) : '0;
  assign rr_nxt         = (int'(g) == TILES - 1) ? '0 : g + 1'b1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (fire) state_d = FULL;
      FULL:  if (AXI_READY && !fire) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      AXI_RESP <= '0;
      AXI_DATA <= '0;
      AXI_TID  <= '0;
      rr_ptr   <= '0;
    end else begin
      state_q <= state_d;
      if (fire) begin
        AXI_RESP <= g_resp;
        AXI_DATA <= g_data;
        AXI_TID  <= g;
        if (MODE == 0) rr_ptr <= rr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_axi_ux_resp_arb.sv
// tb_axi_ux_resp_arb: directed checks of the response concentrator,
// round-robin instance plus addressed instance on shared tile inputs.
module tb_axi_ux_resp_arb;

  localparam int BW = 32;
  localparam int TILES = 16;
  localparam int AT = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [AT-1:0]      sel_addr;
  logic               axi_ready;
  logic [2*TILES-1:0] t_resp;
  logic [TILES-1:0]   t_valid;
  logic [BW*TILES-1:0] t_data;

  logic               rr_valid;
  logic [1:0]         rr_resp;
  logic [BW-1:0]      rr_data;
  logic [AT-1:0]      rr_tid;
  logic [TILES-1:0]   rr_tready;

  logic               ad_valid;
  logic [1:0]         ad_resp;
  logic [BW-1:0]      ad_data;
  logic [AT-1:0]      ad_tid;
  logic [TILES-1:0]   ad_tready;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_ux_resp_arb #(.BW(BW), .TILES(TILES), .ADDR_TILE(AT), .MODE(0)) u_rr (
    .clk(clk), .rst(rst), .sel_addr(sel_addr), .AXI_READY(axi_ready),
    .AXI_VALID(rr_valid), .AXI_RESP(rr_resp), .AXI_DATA(rr_data),
    .AXI_TID(rr_tid), .tile_AXI_RESP(t_resp), .tile_AXI_VALID(t_valid),
    .tile_AXI_DATA(t_data), .tile_AXI_READY(rr_tready)
  );

  axi_ux_resp_arb #(.BW(BW), .TILES(TILES), .ADDR_TILE(AT), .MODE(1)) u_ad (
    .clk(clk), .rst(rst), .sel_addr(sel_addr), .AXI_READY(axi_ready),
    .AXI_VALID(ad_valid), .AXI_RESP(ad_resp), .AXI_DATA(ad_data),
    .AXI_TID(ad_tid), .tile_AXI_RESP(t_resp), .tile_AXI_VALID(t_valid),
    .tile_AXI_DATA(t_data), .tile_AXI_READY(ad_tready)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int seq [6] = '{0, 3, 15, 0, 3, 15};

  initial begin
    rst       = 1'b1;
    sel_addr  = '0;
    axi_ready = 1'b1;
    t_valid   = '1;
    for (int i = 0; i < TILES; i++) begin
      t_data[BW*i +: BW] = 32'hCAFE_0000 | 32'(i);
      t_resp[2*i +: 2]   = 2'(i + 1);
    end

    // reset with every tile requesting
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_valid", rr_valid, 0);
      chk("rst_tready", rr_tready, 0);
      chk("rst_ad_tready", ad_tready, 0);
    end
    rst = 1'b0;
    t_valid = '0;
    #1;
    chk("rst_tid", rr_tid, 0);
    chk("rst_ad_valid", ad_valid, 0);

    // single source, tile 5
    t_valid = 16'h0020;
    #1;
    chk("single_tready", rr_tready, 16'h0020);
    step();
    t_valid = '0;
    #1;
    chk("single_valid", rr_valid, 1);
    chk("single_data", rr_data, 32'hCAFE_0005);
    chk("single_resp", rr_resp, 2);
    chk("single_tid", rr_tid, 5);
    step();
    chk("single_drain", rr_valid, 0);
    chk("single_hold_tid", rr_tid, 5);

    // round-robin wrap across 0,3,15
    rst = 1'b1;
    step();
    rst = 1'b0;
    t_valid = 16'h8009;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_valid", rr_valid, 1);
      chk("rr_tid", rr_tid, 64'(seq[k]));
    end

    // back-pressure with tile 15 held
    axi_ready = 1'b0;
    #1;
    chk("bp_tready0", rr_tready, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("bp_valid", rr_valid, 1);
      chk("bp_tid", rr_tid, 15);
      chk("bp_data", rr_data, 32'hCAFE_000F);
      chk("bp_tready", rr_tready, 0);
    end
    axi_ready = 1'b1;
    #1;
    chk("bp_release", rr_tready, 16'h0001);
    step();
    chk("bp_next_tid", rr_tid, 0);
    step();
    chk("bp_next2_tid", rr_tid, 3);

    // reset while stalled on tile 3
    axi_ready = 1'b0;
    step();
    chk("rs_stall_tid", rr_tid, 3);
    rst = 1'b1;
    step();
    chk("rs_valid", rr_valid, 0);
    chk("rs_tready", rr_tready, 0);
    chk("rs_tid", rr_tid, 0);
    rst = 1'b0;
    axi_ready = 1'b1;
    #1;
    chk("rs_prio", rr_tready, 16'h0001);
    step();
    chk("rs_first_tid", rr_tid, 0);

    // addressed mode
    rst = 1'b1;
    step();
    rst = 1'b0;
    sel_addr = 4'd7;
    t_valid = 16'h0084;
    #1;
    chk("ad_tready", ad_tready, 16'h0080);
    step();
    chk("ad_valid", ad_valid, 1);
    chk("ad_tid", ad_tid, 7);
    chk("ad_data", ad_data, 32'hCAFE_0007);
    chk("ad_resp", ad_resp, 0);
    step();
    chk("ad_tid2", ad_tid, 7);
    t_valid = 16'h0004;
    #1;
    chk("ad_idle_tready", ad_tready, 0);
    step();
    chk("ad_drain", ad_valid, 0);
    chk("ad_hold_tid", ad_tid, 7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/axi_ux_resp_arb.md
Name: axi_ux_resp_arb

Overview:
Registered, arbitrated response-channel concentrator. It merges TILES per-tile AXI response channels (RESP/VALID/DATA) into one controller-side channel.
- A round-robin arbiter, or an externally addressed select, picks the source.
- A one-entry output register slice holds the winner, and the block returns the winning tile index alongside the beat.
- It sits between the tile array and the S-controller's AXI slave interface, where it replaces a purely combinational address-indexed mux.

Parameters:
BW, 32, data width per tile
TILES, 16, number of tile response channels (>=2)
ADDR_TILE, 4, tile index width; must satisfy 2**ADDR_TILE >= TILES
MODE, 0, 0 = round-robin arbitration; 1 = addressed (select from sel_addr)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
sel_addr  input  ADDR_TILE  tile select (MODE=1 only; ignored in MODE=0)
AXI_READY  input  1  controller accepts beat
AXI_VALID  output  1  beat valid
AXI_RESP  output  2  response code of held beat
AXI_DATA  output  BW  data of held beat
AXI_TID  output  ADDR_TILE  source tile of held beat
tile_AXI_RESP  input  2*TILES  per-tile RESP; tile i at [2i+1:2i]
tile_AXI_VALID  input  TILES  per-tile VALID
tile_AXI_DATA  input  BW*TILES  per-tile DATA; tile i at [BW(i+1)-1:BW*i]
tile_AXI_READY  output  TILES  per-tile READY, one-hot or zero

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high: rst is sampled on the rising edge of clk.
- Reset values:
  - AXI_VALID=0, AXI_RESP=0, AXI_DATA=0, AXI_TID=0.
  - Round-robin pointer rr_ptr=0, meaning tile 0 has highest priority next.
  - tile_AXI_READY=0 while rst is high.
- Load enable: load = ~AXI_VALID | AXI_READY. The output slice can accept a new beat in the same cycle the held beat drains, giving throughput of 1 beat/cycle.
- Grant, MODE=0:
  - Combinational search over tile_AXI_VALID, starting at rr_ptr and wrapping modulo TILES.
  - The first asserted index g wins.
  - No valid tile means no grant.
- Grant, MODE=1:
  - g = sel_addr when tile_AXI_VALID[sel_addr]=1.
  - sel_addr >= TILES means no grant and never X-propagates.
- Tile READY: tile_AXI_READY[g] = load & grant_valid; all other bits are 0. READY depends combinationally on AXI_READY and the tile VALIDs. It never depends combinationally on the tile's own READY.
- Transfer on the tile side: occurs when tile_AXI_VALID[g] & tile_AXI_READY[g]. On the next edge:
  - AXI_VALID <= 1
  - AXI_RESP <= RESP[g], AXI_DATA <= DATA[g], AXI_TID <= g
  - MODE=0: rr_ptr <= (g+1) mod TILES, including the wrap from TILES-1 to 0.
- Drain: when AXI_VALID & AXI_READY and there is no new grant, AXI_VALID <= 0 on the next edge. AXI_RESP, AXI_DATA and AXI_TID hold their last values.
- Stall: when AXI_VALID & ~AXI_READY:
  - AXI_RESP, AXI_DATA and AXI_TID are held stable.
  - All tile_AXI_READY are 0.
  - rr_ptr is unchanged.
  - Meets the AXI rule that VALID is not dropped before handshake.
- Latency: 1 cycle from tile handshake to AXI_VALID.
- Fairness (MODE=0): with N tiles continuously valid, each is granted exactly once every N transfers.
- Simultaneous drain and load: the new beat replaces the old one with no bubble.
- Reset mid-transfer: a held beat is discarded (AXI_VALID=0 next cycle) and rr_ptr returns to 0. No tile handshake occurs in the cycle rst is high.
- State: AXI_VALID acts as a 2-state FSM, EMPTY (AXI_VALID=0) and FULL (AXI_VALID=1):
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on drain with no grant.
  - FULL -> FULL on drain with grant, or on stall.

Test Plan:
- Reset: assert rst for 2 cycles with all tile VALIDs=1 -> AXI_VALID=0 and tile_AXI_READY=0 throughout; AXI_TID=0 after rst deasserts.
- Single source, MODE=0: tile 5 valid, DATA=0xCAFE0005, RESP=2'b10, AXI_READY=1 -> tile_AXI_READY=16'h0020 in the same cycle; next cycle AXI_VALID=1, AXI_DATA=0xCAFE0005, AXI_RESP=2, AXI_TID=5.
- Round-robin wrap, MODE=0: tiles 0, 3 and 15 continuously valid, AXI_READY=1 -> AXI_TID sequence 0,3,15,0,3,15, one beat per cycle with no bubbles.
- Back-pressure: AXI_READY=0 for 4 cycles with a beat held -> outputs stable and tile_AXI_READY=0; on the first AXI_READY=1 the next tile is granted in that cycle.
- Addressed, MODE=1: sel_addr=7 with tiles 2 and 7 valid -> only tile 7 served. sel_addr=7 with tile 7 idle -> no grant and AXI_VALID falls after drain.
- Reset mid-stall: beat held with AXI_READY=0, then pulse rst -> AXI_VALID=0 next cycle; after release, tile 0 has priority.
